// File: rtl/servo_speed_ramp.sv
`default_nettype none
// ============================================================================
// Module      : servo_speed_ramp
// Description : Turns a signed speed command into the pulse-width divisor for
//               servo_continuous. The command is clamped to +/-SPEED_MAX, and
//               the applied speed is slewed by at most SLEW_STEP once per PWM
//               frame. The divisor is recomputed two cycles after the frame tick.
// Ports       : clk_in          system clock
//               rst_in          asynchronous active-high reset
//               enable_in       0 forces the effective target to 0
//               speed_in        signed speed command
//               speed_valid_in  command valid
//               speed_ready_out command can be accepted (FSM in WAIT)
//               divisor_out     pulse width in clocks
//               cur_speed_out   currently applied (slewed) speed
//               at_target_out   cur_speed equals effective target
//               frame_tick_out  1-cycle pulse on the last cycle of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module servo_speed_ramp #(
    parameter int unsigned FRAME_CYCLES = 1966080,
    parameter int unsigned NEUTRAL      = 147456,
    parameter int unsigned STEP_CYCLES  = 491,
    parameter int unsigned SPEED_MAX    = 100,
    parameter int unsigned SLEW_STEP    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [7:0]  speed_in,
    input  logic        speed_valid_in,
    output logic        speed_ready_out,
    output logic [21:0] divisor_out,
    output logic [7:0]  cur_speed_out,
    output logic        at_target_out,
    output logic        frame_tick_out
);

    localparam logic        [21:0] c_frame_last  = 22'(FRAME_CYCLES - 1);
    localparam logic        [21:0] c_neutral     = 22'(NEUTRAL);
    localparam logic signed [24:0] c_neutral_ext = 25'(NEUTRAL);
    localparam logic signed [24:0] c_step_mult   = 25'(STEP_CYCLES);
    localparam logic signed [7:0]  c_spd_max     = 8'(SPEED_MAX);
    localparam logic signed [7:0]  c_spd_min     = -c_spd_max;
    localparam logic signed [8:0]  c_slew        = 9'(SLEW_STEP);
    localparam logic signed [8:0]  c_slew_neg    = -c_slew;
    localparam logic signed [7:0]  c_slew_8      = 8'(SLEW_STEP);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_STEP = 2'd1,
        ST_CALC = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic        [21:0] cnt_q, cnt_d;
    logic signed [7:0]  target_q, target_d;
    logic signed [7:0]  cur_q, cur_d;
    logic        [21:0] divisor_q, divisor_d;
    logic               at_target_q, at_target_d;

    logic               tick;
    logic signed [7:0]  cmd;
    logic signed [7:0]  eff_target;
    logic signed [8:0]  diff;

    assign tick       = (cnt_q == c_frame_last);
    assign cmd        = speed_in;
    assign eff_target = enable_in ? target_q : 8'sd0;
    // 9 bits so that e.g. +100 - (-100) cannot overflow
    assign diff       = 9'(eff_target) - 9'(cur_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? 22'd0 : cnt_q + 22'd1;
        target_d    = target_q;
        cur_d       = cur_q;
        divisor_d   = divisor_q;
        at_target_d = at_target_q;

        // Accept only in WAIT; -128 falls under the lower clamp as well
        if (state_q == ST_WAIT && speed_valid_in) begin
            if (cmd > c_spd_max) begin
                target_d = c_spd_max;
            end else if (cmd < c_spd_min) begin
                target_d = c_spd_min;
            end else begin
                target_d = cmd;
            end
        end

        case (state_q)
            ST_WAIT: begin
                if (tick) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (diff > c_slew) begin
                    cur_d = cur_q + c_slew_8;
                end else if (diff < c_slew_neg) begin
                    cur_d = cur_q - c_slew_8;
                end else begin
                    cur_d = eff_target;
                end
                at_target_d = (cur_d == eff_target);
                state_d     = ST_CALC;
            end
            ST_CALC: begin
                // Low 22 bits of the signed sum; parameters keep it in range
                divisor_d = 22'(c_neutral_ext + (25'(cur_q) * c_step_mult));
                state_d   = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_WAIT;
            cnt_q       <= 22'd0;
            target_q    <= 8'sd0;
            cur_q       <= 8'sd0;
            divisor_q   <= c_neutral;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            cur_q       <= cur_d;
            divisor_q   <= divisor_d;
            at_target_q <= at_target_d;
        end
    end

    assign speed_ready_out = (state_q == ST_WAIT);
    assign divisor_out     = divisor_q;
    assign cur_speed_out   = cur_q;
    assign at_target_out   = at_target_q;
    assign frame_tick_out  = tick;

endmodule
`default_nettype wire

// File: tb/tb_servo_speed_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_speed_ramp
// Description : Scoreboard bench for servo_speed_ramp with FRAME_CYCLES=64.
//               Stimulus pushes the expected per-frame result at each tick; a
//               monitor pops and compares once the new divisor is visible.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_speed_ramp;

    localparam int c_frame = 64;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        enable_in = 1'b1;
    logic [7:0]  speed_in = 8'd0;
    logic        speed_valid_in = 1'b0;
    logic        speed_ready_out;
    logic [21:0] divisor_out;
    logic [7:0]  cur_speed_out;
    logic        at_target_out;
    logic        frame_tick_out;

    servo_speed_ramp #(
        .FRAME_CYCLES(c_frame),
        .NEUTRAL     (147456),
        .STEP_CYCLES (491),
        .SPEED_MAX   (100),
        .SLEW_STEP   (4)
    ) u_dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .enable_in      (enable_in),
        .speed_in       (speed_in),
        .speed_valid_in (speed_valid_in),
        .speed_ready_out(speed_ready_out),
        .divisor_out    (divisor_out),
        .cur_speed_out  (cur_speed_out),
        .at_target_out  (at_target_out),
        .frame_tick_out (frame_tick_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cur;
        int div;
        int at;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference state of the ramp
    int   m_target = 0;
    int   m_cur    = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic int cur_s();
        return int'($signed(cur_speed_out));
    endfunction

    // Advance the reference by one frame and queue the expected outcome
    task automatic push_model();
        int eff;
        int d;
        exp_t e;
        eff = enable_in ? m_target : 0;
        d   = eff - m_cur;
        if (d > 4)       m_cur = m_cur + 4;
        else if (d < -4) m_cur = m_cur - 4;
        else             m_cur = eff;
        e.cur = m_cur;
        e.div = 147456 + m_cur * 491;
        e.at  = (m_cur == eff) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk_in);
        while (!frame_tick_out && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (!frame_tick_out) chk("tick_timeout", int'(frame_tick_out), 1);
    endtask

    // One frame: wait for the tick, queue expectation, then move into
    // the quiet part of the frame (counter=3, FSM back in WAIT)
    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            push_model();
            repeat (4) @(negedge clk_in);
        end
    endtask

    task automatic send(input int v);
        int n = 0;
        while (!speed_ready_out && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        speed_in       = 8'(v);
        speed_valid_in = 1'b1;
        @(negedge clk_in);
        speed_valid_in = 1'b0;
        m_target = (v > 100) ? 100 : ((v < -100) ? -100 : v);
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in   = 1'b0;
        m_target = 0;
        m_cur    = 0;
    endtask

    // Monitor: the divisor for a frame is visible 3 cycles after its tick
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (frame_tick_out === 1'b1 && rst_in === 1'b0) begin
                repeat (3) @(negedge clk_in);
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_cur", cur_s(), e.cur);
                    chk("sb_divisor", int'(divisor_out), e.div);
                    chk("sb_at_target", int'(at_target_out), e.at);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got %0d expected %0d", $time, 1_000_000);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // ---- 1: reset state and frame period
        repeat (3) @(negedge clk_in);
        chk("rst_divisor", int'(divisor_out), 147456);
        chk("rst_cur", cur_s(), 0);
        chk("rst_at_target", int'(at_target_out), 1);
        chk("rst_ready", int'(speed_ready_out), 1);
        chk("rst_tick", int'(frame_tick_out), 0);
        rst_in = 1'b0;
        wait_tick();
        push_model();
        n = 0;
        @(negedge clk_in);
        n++;
        while (!frame_tick_out && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk("tick_period", n, c_frame);
        push_model();
        repeat (4) @(negedge clk_in);
        frame(1);

        // ---- 2: ramp to +100
        send(100);
        frame(1);
        chk("t2_frame1_div", int'(divisor_out), 149420);
        chk("t2_frame1_cur", cur_s(), 4);
        frame(24);
        chk("t2_frame25_div", int'(divisor_out), 196556);
        chk("t2_frame25_at", int'(at_target_out), 1);

        // ---- 3: -128 clamps to -100, then full swing to +100
        apply_reset();
        send(-128);
        frame(25);
        chk("t3_neg_div", int'(divisor_out), 98356);
        chk("t3_neg_cur", cur_s(), -100);
        send(100);
        frame(49);
        chk("t3_f49_div", int'(divisor_out), 194592);
        chk("t3_f49_at", int'(at_target_out), 0);
        frame(1);
        chk("t3_f50_div", int'(divisor_out), 196556);
        chk("t3_f50_at", int'(at_target_out), 1);

        // ---- 4: accept in tick cycle, valid held through STEP/CALC
        apply_reset();
        frame(1);
        repeat (60) @(negedge clk_in);
        chk("t4_in_tick", int'(frame_tick_out), 1);
        speed_in       = 8'd20;
        speed_valid_in = 1'b1;
        m_target       = 20;
        push_model();
        @(negedge clk_in);                      // T+1 (STEP)
        chk("t4_t1_ready", int'(speed_ready_out), 0);
        chk("t4_t1_cur", cur_s(), 0);
        speed_in = 8'hF8;                       // -8, held while not ready
        @(negedge clk_in);                      // T+2 (CALC)
        chk("t4_t2_ready", int'(speed_ready_out), 0);
        chk("t4_t2_cur", cur_s(), 4);
        chk("t4_t2_div", int'(divisor_out), 147456);
        @(negedge clk_in);                      // T+3 (WAIT, accept)
        chk("t4_t3_ready", int'(speed_ready_out), 1);
        chk("t4_t3_div", int'(divisor_out), 149420);
        m_target = -8;
        @(negedge clk_in);
        speed_valid_in = 1'b0;
        frame(3);
        chk("t4_final_div", int'(divisor_out), 143528);
        chk("t4_final_at", int'(at_target_out), 1);

        // ---- 5: enable off ramps to stop, on ramps back
        apply_reset();
        send(40);
        frame(10);
        chk("t5_at40", cur_s(), 40);
        enable_in = 1'b0;
        frame(1);
        chk("t5_first_down", cur_s(), 36);
        frame(9);
        chk("t5_stop_div", int'(divisor_out), 147456);
        chk("t5_stop_at", int'(at_target_out), 1);
        enable_in = 1'b1;
        frame(10);
        chk("t5_back_div", int'(divisor_out), 167096);

        // ---- 6: async reset mid-ramp
        apply_reset();
        send(100);
        frame(5);
        chk("t6_pre_cur", cur_s(), 20);
        repeat (10) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("t6_rst_div", int'(divisor_out), 147456);
        chk("t6_rst_cur", cur_s(), 0);
        chk("t6_rst_ready", int'(speed_ready_out), 1);
        repeat (2) @(negedge clk_in);
        rst_in   = 1'b0;
        m_target = 0;
        m_cur    = 0;
        frame(2);
        chk("t6_hold_cur", cur_s(), 0);
        send(100);
        frame(2);
        chk("t6_restart_cur", cur_s(), 8);
        chk("t6_restart_div", int'(divisor_out), 151384);

        repeat (10) @(negedge clk_in);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
